// File: rtl/step_ctrl_pkg.sv
// Shared definitions for the CPU step controller: mode encodings and
// debounce state machine states.
package step_ctrl_pkg;

    localparam logic [1:0] MODE_HALT = 2'b00;
    localparam logic [1:0] MODE_STEP = 2'b01;
    localparam logic [1:0] MODE_SLOW = 2'b10;
    localparam logic [1:0] MODE_FAST = 2'b11;

    typedef enum logic [1:0] {
        IDLE  = 2'b00,
        PRESS = 2'b01,
        HELD  = 2'b10,
        REL   = 2'b11
    } db_state_t;

endpackage

// File: rtl/btn_debounce.sv
// Two-flop button synchronizer followed by a press/release debounce FSM that
// emits a single-cycle press pulse per accepted press.
module btn_debounce
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 500_000
) (
    input  logic clk_in,
    input  logic reset,
    input  logic step_btn,
    output logic press
);

    localparam int unsigned CW = (DEBOUNCE > 1) ? $clog2(DEBOUNCE) : 1;
    localparam logic [CW-1:0] CNT_TOP = CW'(DEBOUNCE - 1);

    logic          btn_s1;
    logic          btn_s2;
    db_state_t     state;
    logic [CW-1:0] cnt;

    // Both edges of the button must hold for DEBOUNCE cycles to be accepted.
    always_ff @(posedge clk_in) begin
        if (reset) begin
            btn_s1 <= 1'b0;
            btn_s2 <= 1'b0;
            state  <= IDLE;
            cnt    <= '0;
            press  <= 1'b0;
        end else begin
            btn_s1 <= step_btn;
            btn_s2 <= btn_s1;
            press  <= 1'b0;
            case (state)
                IDLE: begin
                    if (btn_s2) begin
                        state <= PRESS;
                        cnt   <= '0;
                    end
                end
                PRESS: begin
                    if (!btn_s2) begin
                        state <= IDLE;
                    end else if (cnt == CNT_TOP) begin
                        state <= HELD;
                        press <= 1'b1;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                HELD: begin
                    if (!btn_s2) begin
                        state <= REL;
                        cnt   <= '0;
                    end
                end
                REL: begin
                    if (btn_s2) begin
                        state <= HELD;
                    end else if (cnt == CNT_TOP) begin
                        state <= IDLE;
                    end else begin
                        cnt <= cnt + CW'(1);
                    end
                end
                default: state <= IDLE;
            endcase
        end
    end

endmodule

// File: rtl/step_ctrl.sv
// CPU clock-enable generator: halt, debounced single-step, slow run on the
// divided clock, and fast run, with sticky CPU halt and saturating step count.
module step_ctrl
    import step_ctrl_pkg::*;
#(
    parameter int unsigned DEBOUNCE = 500_000,
    parameter int unsigned CNT_W    = 16
) (
    input  logic             clk_in,
    input  logic             reset,
    input  logic             slow_clk,
    input  logic             step_btn,
    input  logic [1:0]       mode,
    input  logic             halt_req,
    output logic             cpu_en,
    output logic [CNT_W-1:0] step_count,
    output logic             running,
    output logic             halted
);

    localparam logic [CNT_W-1:0] CNT_MAX = {CNT_W{1'b1}};

    logic press;
    logic slow_s1;
    logic slow_s2;
    logic slow_s3;
    logic slow_rise_c;
    logic go_c;
    logic halted_next_c;

    btn_debounce #(
        .DEBOUNCE (DEBOUNCE)
    ) u_btn_debounce (
        .clk_in   (clk_in),
        .reset    (reset),
        .step_btn (step_btn),
        .press    (press)
    );

    // Step request selection and halt flag update; halt_req wins over clear.
    always_comb begin
        slow_rise_c   = slow_s2 & ~slow_s3;
        go_c          = 1'b0;
        halted_next_c = halted;
        case (mode)
            MODE_FAST: go_c = 1'b1;
            MODE_SLOW: go_c = slow_rise_c;
            MODE_STEP: go_c = press;
            default:   go_c = 1'b0;
        endcase
        if (halt_req) begin
            halted_next_c = 1'b1;
        end else if (mode == MODE_HALT) begin
            halted_next_c = 1'b0;
        end
    end

    always_ff @(posedge clk_in) begin
        if (reset) begin
            slow_s1    <= 1'b0;
            slow_s2    <= 1'b0;
            slow_s3    <= 1'b0;
            cpu_en     <= 1'b0;
            step_count <= '0;
            running    <= 1'b0;
            halted     <= 1'b0;
        end else begin
            slow_s1    <= slow_clk;
            slow_s2    <= slow_s1;
            slow_s3    <= slow_s2;
            cpu_en     <= go_c & ~halted & ~halt_req;
            halted     <= halted_next_c;
            running    <= (mode != MODE_HALT) & ~halted_next_c;
            if (cpu_en && (step_count != CNT_MAX)) begin
                step_count <= step_count + CNT_W'(1);
            end
        end
    end

endmodule

// File: tb/tb_step_ctrl.sv
// Directed self-checking bench for step_ctrl with DEBOUNCE=4, CNT_W=4.
module tb_step_ctrl;

    logic       clk_in;
    logic       reset;
    logic       slow_clk;
    logic       step_btn;
    logic [1:0] mode;
    logic       halt_req;
    logic       cpu_en;
    logic [3:0] step_count;
    logic       running;
    logic       halted;

    int checks;
    int errors;

    step_ctrl #(
        .DEBOUNCE (4),
        .CNT_W    (4)
    ) dut (
        .clk_in     (clk_in),
        .reset      (reset),
        .slow_clk   (slow_clk),
        .step_btn   (step_btn),
        .mode       (mode),
        .halt_req   (halt_req),
        .cpu_en     (cpu_en),
        .step_count (step_count),
        .running    (running),
        .halted     (halted)
    );

    initial clk_in = 1'b0;
    always #5 clk_in = ~clk_in;

    // Advance one edge and settle just after it.
    task automatic tick();
        @(posedge clk_in);
        #1;
    endtask

    task automatic chk(input string tag, input logic [31:0] obs, input logic [31:0] exp);
        checks++;
        assert (obs === exp) else begin
            errors++;
            $error("FAIL %s observed %0h expected %0h", tag, obs, exp);
        end
    endtask

    initial begin
        checks   = 0;
        errors   = 0;
        reset    = 1'b1;
        slow_clk = 1'b0;
        step_btn = 1'b0;
        mode     = 2'b00;
        halt_req = 1'b0;
        tick();
        tick();
        chk("rst_cpu_en", 32'(cpu_en), 0);
        chk("rst_count", 32'(step_count), 0);
        chk("rst_running", 32'(running), 0);
        chk("rst_halted", 32'(halted), 0);

        // Fast run: enable every cycle, count saturates at 15.
        reset = 1'b0;
        mode  = 2'b11;
        for (int i = 1; i <= 20; i++) begin
            tick();
            chk("fast_en", 32'(cpu_en), 1);
            chk("fast_count", 32'(step_count), (i - 1 > 15) ? 15 : i - 1);
        end
        chk("fast_running", 32'(running), 1);

        // Slow run: one pulse two edges after each slow_clk rise.
        reset = 1'b1;
        mode  = 2'b10;
        tick();
        reset = 1'b0;
        for (int t = 0; t < 36; t++) begin
            slow_clk = ((t / 6) % 2) == 1;
            tick();
            chk("slow_en", 32'(cpu_en), 32'((t == 8) || (t == 20) || (t == 32)));
        end
        chk("slow_count", 32'(step_count), 3);
        slow_clk = 1'b0;

        // Step mode: glitches rejected, one pulse from the stable press.
        reset = 1'b1;
        mode  = 2'b01;
        tick();
        reset = 1'b0;
        for (int t = 0; t < 25; t++) begin
            case (t)
                0, 2, 3: step_btn = 1'b1;
                1, 4:    step_btn = 1'b0;
                default: step_btn = (t < 15);
            endcase
            tick();
            chk("step_en", 32'(cpu_en), 32'(t == 12));
        end
        chk("step_count", 32'(step_count), 1);

        // Halt request stops the CPU and sticks until halt mode.
        mode = 2'b11;
        tick();
        tick();
        chk("pre_halt_en", 32'(cpu_en), 1);
        halt_req = 1'b1;
        tick();
        chk("halt_en", 32'(cpu_en), 0);
        chk("halt_flag", 32'(halted), 1);
        chk("halt_running", 32'(running), 0);
        halt_req = 1'b0;
        tick();
        chk("halt_sticky", 32'(halted), 1);
        chk("halt_sticky_en", 32'(cpu_en), 0);
        mode     = 2'b10;
        slow_clk = 1'b1;
        for (int i = 0; i < 4; i++) begin
            tick();
            chk("halt_slow_en", 32'(cpu_en), 0);
        end
        chk("halt_slow_flag", 32'(halted), 1);
        slow_clk = 1'b0;
        mode     = 2'b00;
        tick();
        chk("clear_halted", 32'(halted), 0);
        chk("clear_running", 32'(running), 0);
        mode = 2'b11;
        tick();
        chk("resume_en", 32'(cpu_en), 1);
        chk("resume_running", 32'(running), 1);

        // Halt request coinciding with halt mode: halt wins.
        mode     = 2'b00;
        halt_req = 1'b1;
        tick();
        chk("coinc_halted", 32'(halted), 1);
        chk("coinc_en", 32'(cpu_en), 0);
        halt_req = 1'b0;
        tick();
        chk("coinc_clear", 32'(halted), 0);
        chk("coinc_running", 32'(running), 0);

        // Reset during a press: aborted press emits nothing, fresh press works.
        mode     = 2'b01;
        step_btn = 1'b1;
        for (int i = 0; i < 5; i++) begin
            tick();
            chk("abort_en", 32'(cpu_en), 0);
        end
        reset = 1'b1;
        tick();
        chk("abort_rst_en", 32'(cpu_en), 0);
        chk("abort_rst_count", 32'(step_count), 0);
        reset = 1'b0;
        for (int r = 1; r <= 12; r++) begin
            tick();
            chk("fresh_en", 32'(cpu_en), 32'(r == 8));
        end
        chk("fresh_count", 32'(step_count), 1);
        step_btn = 1'b0;
        tick();

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
